// File: rtl/rob_trap_ctrl.sv
// ROB-head retirement and trap controller.
// Retires completed head entries. Turns a faulting head into a trap report
// followed by a flush and a redirect to the trap vector. A serialising head
// retires and then refetches at pc+1 (word address). After every flush the
// block waits DRAIN_CYCLES cycles before it accepts the head again.
module rob_trap_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        head_valid,
  input  logic [6:0]  head_robid,
  input  logic [29:0] head_pc,
  input  logic        head_error,
  input  logic [4:0]  head_ecause,
  input  logic [31:0] head_tval,
  input  logic        head_serial,
  output logic        head_ack,
  output logic        rob_ret_valid,
  output logic        rob_csr_valid,
  output logic [6:0]  rob_csr_head,
  output logic [29:0] rob_csr_epc,
  output logic [4:0]  rob_csr_ecause,
  output logic [31:0] rob_csr_tval,
  input  logic [29:0] csr_tvec,
  output logic        rob_flush,
  output logic        redirect_valid,
  output logic [29:0] redirect_pc,
  output logic [15:0] trap_count
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] TRAP  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        ret_valid_q, ret_valid_d;
  logic [6:0]  head_q, head_d;
  logic [29:0] epc_q, epc_d;
  logic [4:0]  ecause_q, ecause_d;
  logic [31:0] tval_q, tval_d;
  logic [29:0] target_q, target_d;
  logic        from_trap_q, from_trap_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] trap_count_q, trap_count_d;

  // Next-state and head handshake; a trapping head is never acked.
  always_comb begin
    state_d      = state_q;
    ret_valid_d  = 1'b0;
    head_d       = head_q;
    epc_d        = epc_q;
    ecause_d     = ecause_q;
    tval_d       = tval_q;
    target_d     = target_q;
    from_trap_d  = from_trap_q;
    cnt_d        = cnt_q;
    trap_count_d = trap_count_q;
    head_ack     = 1'b0;
    case (state_q)
      RUN: begin
        if (head_valid) begin
          if (head_error) begin
            // Error wins over serial: capture the trap report.
            head_d       = head_robid;
            epc_d        = head_pc;
            ecause_d     = head_ecause;
            tval_d       = head_tval;
            from_trap_d  = 1'b1;
            trap_count_d = trap_count_q + 16'd1;
            state_d      = TRAP;
          end else begin
            head_ack    = 1'b1;
            ret_valid_d = 1'b1;
            head_d      = head_robid;
            if (head_serial) begin
              target_d    = head_pc + 30'd1;
              from_trap_d = 1'b0;
              state_d     = FLUSH;
            end
          end
        end
      end
      TRAP:  state_d = FLUSH;
      FLUSH: begin
        cnt_d   = 4'(DRAIN_CYCLES - 1);
        state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // State and report registers; reset drops any pending flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      ret_valid_q  <= 1'b0;
      head_q       <= '0;
      epc_q        <= '0;
      ecause_q     <= '0;
      tval_q       <= '0;
      target_q     <= '0;
      from_trap_q  <= 1'b0;
      cnt_q        <= '0;
      trap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ret_valid_q  <= ret_valid_d;
      head_q       <= head_d;
      epc_q        <= epc_d;
      ecause_q     <= ecause_d;
      tval_q       <= tval_d;
      target_q     <= target_d;
      from_trap_q  <= from_trap_d;
      cnt_q        <= cnt_d;
      trap_count_q <= trap_count_d;
    end
  end

  // Pulses decode straight from the state flop; the trap vector is taken live in FLUSH.
  always_comb begin
    rob_ret_valid  = ret_valid_q;
    rob_csr_valid  = (state_q == TRAP);
    rob_flush      = (state_q == FLUSH);
    redirect_valid = (state_q == FLUSH);
    redirect_pc    = '0;
    if (state_q == FLUSH) redirect_pc = from_trap_q ? csr_tvec : target_q;
    rob_csr_head   = head_q;
    rob_csr_epc    = epc_q;
    rob_csr_ecause = ecause_q;
    rob_csr_tval   = tval_q;
    trap_count     = trap_count_q;
  end

endmodule
